// File: rtl/display_arbiter.sv
// Two-source round-robin arbiter for a shared seven-segment display.
// A granted source keeps the display for at least HOLD_CYCLES clocks.
module display_arbiter #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] word0,
  input  logic        req1,
  input  logic [15:0] word1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] word2display,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

  localparam logic [25:0] HOLD_MAX = 26'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [25:0] cnt_q, cnt_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        busy_q, busy_d;
  logic [15:0] word_q, word_d;
  logic        expired;

  assign expired = (cnt_q == HOLD_MAX);

  // last_q resets to 1 so that source 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      word_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && (!req1 || last_q)) begin
          state_d = HOLD0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = HOLD1;
          last_d  = 1'b1;
        end
      end
      HOLD0: begin
        if (!expired) begin
          cnt_d = cnt_q + 26'd1;
        end else if (req1) begin
          state_d = HOLD1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (!req0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HOLD1: begin
        if (!expired) begin
          cnt_d = cnt_q + 26'd1;
        end else if (req0) begin
          state_d = HOLD0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (!req1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The display word follows the current owner one cycle behind its grant
  always_comb begin
    gnt0_d = (state_d == HOLD0);
    gnt1_d = (state_d == HOLD1);
    busy_d = gnt0_d | gnt1_d;
    word_d = word_q;
    if (gnt0_q) begin
      word_d = word0;
    end else if (gnt1_q) begin
      word_d = word1;
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign busy         = busy_q;
  assign word2display = word_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: one instance with HOLD_CYCLES=4 and
// one with HOLD_CYCLES=1, expectations queued per clock edge.
module tb_display_arbiter;

  typedef struct {
    logic        g0;
    logic        g1;
    logic        busy;
    logic [15:0] word;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req0, req1, req0_b, req1_b;
  logic [15:0] word0, word1;
  logic        gnt0, gnt1, busy;
  logic [15:0] word2display;
  logic        gnt0_b, gnt1_b, busy_b;
  logic [15:0] word2display_b;

  exp_t q_main[$];
  exp_t q_rr[$];
  int   checks   = 0;
  int   failures = 0;

  display_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .word0(word0), .req1(req1), .word1(word1),
    .gnt0(gnt0), .gnt1(gnt1), .word2display(word2display), .busy(busy)
  );

  display_arbiter #(.HOLD_CYCLES(1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0(req0_b), .word0(word0), .req1(req1_b), .word1(word1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .word2display(word2display_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input logic ag0, input logic ag1, input logic abusy,
                             input logic [15:0] aword, input exp_t e);
    checks++;
    if ({ag0, ag1, abusy, aword} !== {e.g0, e.g1, e.busy, e.word}) begin
      failures++;
      $display("[TB] FAIL %s: got gnt0=%b gnt1=%b busy=%b word=%h, expected gnt0=%b gnt1=%b busy=%b word=%h",
               e.name, ag0, ag1, abusy, aword, e.g0, e.g1, e.busy, e.word);
    end
  endtask

  // Drive inputs for the next rising edge and queue what the DUT must show after it
  task automatic applyStimulus(input bit inst, input logic r0, input logic r1,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic eg0, input logic eg1,
                               input logic [15:0] ew, input string name);
    exp_t x;
    @(negedge clk);
    word0 = w0;
    word1 = w1;
    x.g0   = eg0;
    x.g1   = eg1;
    x.busy = eg0 | eg1;
    x.word = ew;
    x.name = name;
    if (inst == 1'b0) begin
      req0 = r0;
      req1 = r1;
      q_main.push_back(x);
    end else begin
      req0_b = r0;
      req1_b = r1;
      q_rr.push_back(x);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_main.size() > 0) begin
        e = q_main.pop_front();
        checkOutput(gnt0, gnt1, busy, word2display, e);
      end
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        checkOutput(gnt0_b, gnt1_b, busy_b, word2display_b, e);
      end
    end
  end

  initial begin
    exp_t z;
    z.g0 = 1'b0; z.g1 = 1'b0; z.busy = 1'b0; z.word = 16'h0000;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    word0 = 16'h0000; word1 = 16'h0000;
    repeat (2) @(negedge clk);
    z.name = "reset_main";
    checkOutput(gnt0, gnt1, busy, word2display, z);
    z.name = "reset_rr";
    checkOutput(gnt0_b, gnt1_b, busy_b, word2display_b, z);
    rst = 1'b0;

    // Tie from reset: source 0 first, then alternate every 4 cycles
    applyStimulus(0, 1, 1, 16'hAAAA, 16'h5555, 1, 0, 16'h0000, "tie_1");
    for (int i = 2; i <= 4; i++)
      applyStimulus(0, 1, 1, 16'hAAAA, 16'h5555, 1, 0, 16'hAAAA, $sformatf("tie_%0d", i));
    applyStimulus(0, 1, 1, 16'hAAAA, 16'h5555, 0, 1, 16'hAAAA, "tie_5");
    for (int i = 6; i <= 8; i++)
      applyStimulus(0, 1, 1, 16'hAAAA, 16'h5555, 0, 1, 16'h5555, $sformatf("tie_%0d", i));
    applyStimulus(0, 1, 1, 16'hAAAA, 16'h5555, 1, 0, 16'h5555, "tie_9");
    applyStimulus(0, 1, 1, 16'hAAAA, 16'h5555, 1, 0, 16'hAAAA, "tie_10");
    applyStimulus(0, 0, 0, 16'hAAAA, 16'h5555, 1, 0, 16'hAAAA, "tie_drop_11");
    applyStimulus(0, 0, 0, 16'hAAAA, 16'h5555, 1, 0, 16'hAAAA, "tie_drop_12");
    applyStimulus(0, 0, 0, 16'hAAAA, 16'h5555, 0, 0, 16'hAAAA, "tie_idle_13");
    applyStimulus(0, 0, 0, 16'hAAAA, 16'h5555, 0, 0, 16'hAAAA, "tie_idle_14");

    // Source 1 alone, one-cycle request still gets the full hold
    applyStimulus(0, 0, 1, 16'hAAAA, 16'h1234, 0, 1, 16'hAAAA, "req1_1");
    for (int i = 2; i <= 4; i++)
      applyStimulus(0, 0, 0, 16'hAAAA, 16'h1234, 0, 1, 16'h1234, $sformatf("req1_%0d", i));
    applyStimulus(0, 0, 0, 16'hAAAA, 16'h1234, 0, 0, 16'h1234, "req1_idle_5");
    applyStimulus(0, 0, 0, 16'hAAAA, 16'h1234, 0, 0, 16'h1234, "req1_idle_6");

    // Source 0 pulse; word holds once idle even if word0 changes
    applyStimulus(0, 1, 0, 16'h0BEE, 16'h1234, 1, 0, 16'h1234, "pulse0_1");
    for (int i = 2; i <= 4; i++)
      applyStimulus(0, 0, 0, 16'h0BEE, 16'h1234, 1, 0, 16'h0BEE, $sformatf("pulse0_%0d", i));
    applyStimulus(0, 0, 0, 16'h0BEE, 16'h1234, 0, 0, 16'h0BEE, "pulse0_idle_5");
    applyStimulus(0, 0, 0, 16'hFFFF, 16'h1234, 0, 0, 16'h0BEE, "pulse0_hold_6");

    // Source 0 held alone beyond expiry, then source 1 takes over within one cycle
    applyStimulus(0, 1, 0, 16'h0C0C, 16'h0D0D, 1, 0, 16'h0BEE, "held0_1");
    for (int i = 2; i <= 10; i++)
      applyStimulus(0, 1, 0, 16'h0C0C, 16'h0D0D, 1, 0, 16'h0C0C, $sformatf("held0_%0d", i));
    applyStimulus(0, 1, 1, 16'h0C0C, 16'h0D0D, 0, 1, 16'h0C0C, "switch_11");
    applyStimulus(0, 0, 0, 16'h0C0C, 16'h0D0D, 0, 1, 16'h0D0D, "hold1_12");
    applyStimulus(0, 0, 0, 16'h0C0C, 16'h0D0D, 0, 1, 16'h0D0D, "hold1_13");
    @(negedge clk);

    // Asynchronous reset mid-grant, then the first tie goes to source 0
    rst = 1'b1;
    #1;
    z.name = "async_reset";
    checkOutput(gnt0, gnt1, busy, word2display, z);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1, 1, 16'h0E0E, 16'h0F0F, 1, 0, 16'h0000, "post_reset_1");
    for (int i = 2; i <= 4; i++)
      applyStimulus(0, 0, 0, 16'h0E0E, 16'h0F0F, 1, 0, 16'h0E0E, $sformatf("post_reset_%0d", i));
    applyStimulus(0, 0, 0, 16'h0E0E, 16'h0F0F, 0, 0, 16'h0E0E, "post_reset_idle_5");

    // HOLD_CYCLES=1 instance: per-cycle alternation under contention
    applyStimulus(1, 1, 1, 16'h1111, 16'h2222, 1, 0, 16'h0000, "rr_1");
    for (int i = 2; i <= 6; i++)
      applyStimulus(1, 1, 1, 16'h1111, 16'h2222, (i % 2) == 1, (i % 2) == 0,
                    ((i % 2) == 0) ? 16'h1111 : 16'h2222, $sformatf("rr_%0d", i));
    applyStimulus(1, 0, 0, 16'h1111, 16'h2222, 0, 0, 16'h2222, "rr_idle_7");
    applyStimulus(1, 0, 0, 16'h1111, 16'h2222, 0, 0, 16'h2222, "rr_idle_8");
    repeat (2) @(negedge clk);

    checks++;
    if (q_main.size() != 0 || q_rr.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0",
               q_main.size(), q_rr.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, 50000000, minimum number of clk cycles a granted source owns the display (1 s at 50 MHz); legal range 1 to 2^26-1.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 req0  input  1  source 0 requests the display.
REQ-005 word0  input  16  source 0 display word (e.g. pushbutton count).
REQ-006 req1  input  1  source 1 requests the display.
REQ-007 word1  input  16  source 1 display word.
REQ-008 gnt0  output  1  source 0 owns the display; registered.
REQ-009 gnt1  output  1  source 1 owns the display; registered.
REQ-010 word2display  output  16  word for the seven-segment driver; registered.
REQ-011 busy  output  1  high while either grant is high; registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, HOLD0, HOLD1; gnt0=1 only in HOLD0, gnt1=1 only in HOLD1, never both.
REQ-013 A 1-bit last-served pointer SHALL record the most recently granted source.
REQ-014 In IDLE, only req0 -> HOLD0; only req1 -> HOLD1; both -> the source not equal to last-served; none -> stay IDLE.
REQ-015 Grant latency SHALL be one cycle: request sampled on edge k -> grant high after edge k.
REQ-016 A 26-bit hold counter SHALL clear to 0 on every entry to HOLD0/HOLD1 and increment once per cycle while held, saturating at HOLD_CYCLES-1.
REQ-017 Hold expiry is the cycle the counter equals HOLD_CYCLES-1; no transition out of HOLDx occurs before expiry, so every grant lasts at least HOLD_CYCLES cycles.
REQ-018 At expiry, other source requesting -> switch directly to the other HOLD state (no IDLE cycle), counter cleared, last-served updated.
REQ-019 At expiry, other not requesting and owner's req high -> remain in HOLDx, counter stays saturated; rule re-evaluated every cycle.
REQ-020 At expiry, neither requesting -> IDLE next cycle.
REQ-021 Owner dropping req before expiry SHALL NOT shorten the grant; release at expiry per REQ-018/020.
REQ-022 word2display SHALL load word0 each cycle gnt0 is high and word1 each cycle gnt1 is high (one cycle behind the live input); in IDLE it holds its last value.
REQ-023 HOLD_CYCLES=1 SHALL give expiry on the first grant cycle, i.e. per-cycle round-robin under contention.

Reset
REQ-024 While rst is high: state IDLE, gnt0=0, gnt1=0, busy=0, word2display=16'h0000, hold counter 0, last-served=1 so source 0 wins the first tie.
REQ-025 Reset asserted mid-grant SHALL clear all outputs immediately, without waiting for a clock edge; first grant is evaluated on the first edge after rst falls.

Verification (HOLD_CYCLES=4)
REQ-026 After reset, req0=req1=1 together -> gnt0=1 on next edge for exactly 4 cycles, then gnt1=1 with no gap; both held -> ownership alternates every 4 cycles.
REQ-027 req1 only, word1=16'h1234 -> gnt1=1 one edge later, word2display=16'h1234 one edge after that, busy=1.
REQ-028 req0 pulsed for 1 cycle -> gnt0 high exactly 4 cycles, then IDLE, busy=0, word2display holds last word0.
REQ-029 req0 held alone for 20 cycles -> gnt0 stays high continuously; req1 asserted at cycle 10 -> gnt1 on the edge after the next expiry evaluation, at most 1 cycle delay since counter is saturated.
REQ-030 rst pulsed during HOLD1 at counter=2 -> gnt1, busy, word2display go 0 asynchronously; with req0=req1=1 after release, gnt0 wins.
REQ-031 HOLD_CYCLES=1 rebuild, req0=req1=1 -> gnt0, gnt1 alternate every cycle, never both high.
